sd_fifo_wr_arbiter: RTL and testbench

Write-side arbiter and burst sequencer for the SD controller's `async_fifo` write port. It shares one FIFO write port between `N_REQ` requesters, such as the SD data-block receiver and the command-response capture. Each grant is held for an atomic burst of programmed length, so words from different sources never interleave. It runs entirely in the `wr_clk` domain and drives `wr_en`/`din` directly from the FIFO's `full` flag.

---
 rtl/sd_fifo_wr_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_sd_fifo_wr_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_fifo_wr_arbiter.sv
// sd_fifo_wr_arbiter
//   Write-side arbiter and burst sequencer for the SD controller async_fifo
//   write port. Round-robin grants one requester at a time and holds the grant
//   for an atomic burst of (req_len+1) words, so words from different sources
//   never interleave. An idle timeout aborts a burst whose source stops
//   supplying data; cycles stalled by fifo_full never count toward it.
//
// Ports (wr_clk domain, rst asynchronous active-high):
//   i_req[N_REQ]            per-requester burst request (level)
//   i_req_len[N_REQ*LEN_W]  per-requester burst length minus one
//   i_src_valid[N_REQ]      per-requester data valid
//   i_src_data[N_REQ*WIDTH] per-requester data word
//   o_gnt[N_REQ]            one-hot grant (registered)
//   o_src_ready[N_REQ]      word accepted when valid & ready (combinational)
//   o_fifo_wr_en/o_fifo_din FIFO write port (combinational from i_fifo_full)
//   i_fifo_full             FIFO full flag
//   o_busy                  burst in progress
//   o_cur_src               granted / last granted requester index
//   o_burst_done            one-cycle pulse, burst completed
//   o_burst_abort           one-cycle pulse, burst aborted by timeout
module sd_fifo_wr_arbiter #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned N_REQ = 2,
  parameter  int unsigned LEN_W = 4,
  parameter  int unsigned TMO_W = 4,
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                     wr_clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*LEN_W-1:0]   i_req_len,
  input  logic [N_REQ-1:0]         i_src_valid,
  input  logic [N_REQ*WIDTH-1:0]   i_src_data,
  output logic [N_REQ-1:0]         o_gnt,
  output logic [N_REQ-1:0]         o_src_ready,
  output logic                     o_fifo_wr_en,
  output logic [WIDTH-1:0]         o_fifo_din,
  input  logic                     i_fifo_full,
  output logic                     o_busy,
  output logic [IDX_W-1:0]         o_cur_src,
  output logic                     o_burst_done,
  output logic                     o_burst_abort
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_t;

  // Registered state
  state_t             r_state;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_cur_src;
  logic [LEN_W-1:0]   r_cnt;
  logic [TMO_W-1:0]   r_tmo;
  logic [N_REQ-1:0]   r_gnt;
  logic               r_done;
  logic               r_abort;

  // Next-state values
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   w_rr_nxt;
  logic [IDX_W-1:0]   w_cur_nxt;
  logic [LEN_W-1:0]   w_cnt_nxt;
  logic [TMO_W-1:0]   w_tmo_nxt;
  logic [N_REQ-1:0]   w_gnt_nxt;
  logic               w_done_nxt;
  logic               w_abort_nxt;

  // Unpacked per-requester fields
  logic [LEN_W-1:0]   w_len  [N_REQ];
  logic [WIDTH-1:0]   w_data [N_REQ];

  logic               w_busy;
  logic               w_cur_valid;
  logic               w_wr;
  logic               w_idle_tick;
  logic               w_sel_found;
  logic [IDX_W-1:0]   w_sel;
  logic [N_REQ-1:0]   w_sel_onehot;

  // (p + off) mod N_REQ; both operands are below N_REQ so one subtract suffices
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] p,
                                                input int unsigned    off);
    int unsigned s;
    s = 32'(p) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return IDX_W'(s);
  endfunction

  // Slice the flat request/data buses into per-requester fields
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign w_len[gi]  = i_req_len[gi*LEN_W +: LEN_W];
    assign w_data[gi] = i_src_data[gi*WIDTH +: WIDTH];
  end

  // Round-robin pick: first requester at or above rr_ptr, wrapping
  always_comb begin
    w_sel_found = 1'b0;
    w_sel       = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      if (!w_sel_found && i_req[wrap_add(r_rr_ptr, off)]) begin
        w_sel_found = 1'b1;
        w_sel       = wrap_add(r_rr_ptr, off);
      end
    end
  end

  assign w_sel_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << w_sel;

  // Write qualification; full stalls neither write nor count toward timeout
  assign w_busy      = (r_state == S_XFER);
  assign w_cur_valid = i_src_valid[r_cur_src];
  assign w_wr        = w_busy & w_cur_valid & ~i_fifo_full;
  assign w_idle_tick = w_busy & ~w_cur_valid & ~i_fifo_full;

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_cur_nxt   = r_cur_src;
    w_cnt_nxt   = r_cnt;
    w_tmo_nxt   = r_tmo;
    w_gnt_nxt   = r_gnt;
    w_done_nxt  = 1'b0;
    w_abort_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_sel_found) begin
          w_cur_nxt   = w_sel;
          w_cnt_nxt   = w_len[w_sel];
          w_tmo_nxt   = '0;
          w_gnt_nxt   = w_sel_onehot;
          w_state_nxt = S_XFER;
        end
      end

      S_XFER: begin
        if (w_wr) begin
          w_tmo_nxt = '0;
          if (r_cnt == '0) begin
            w_gnt_nxt   = '0;
            w_done_nxt  = 1'b1;
            w_rr_nxt    = wrap_add(r_cur_src, 1);
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt - LEN_W'(1);
          end
        end else if (w_idle_tick) begin
          if (r_tmo == '1) begin
            w_gnt_nxt   = '0;
            w_abort_nxt = 1'b1;
            w_rr_nxt    = wrap_add(r_cur_src, 1);
            w_state_nxt = S_IDLE;
          end else begin
            w_tmo_nxt = r_tmo + TMO_W'(1);
          end
        end
      end

      default: begin
        w_gnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= '0;
      r_cur_src <= '0;
      r_cnt     <= '0;
      r_tmo     <= '0;
      r_gnt     <= '0;
      r_done    <= 1'b0;
      r_abort   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rr_ptr  <= w_rr_nxt;
      r_cur_src <= w_cur_nxt;
      r_cnt     <= w_cnt_nxt;
      r_tmo     <= w_tmo_nxt;
      r_gnt     <= w_gnt_nxt;
      r_done    <= w_done_nxt;
      r_abort   <= w_abort_nxt;
    end
  end

  // Only the granted source sees ready, and only when the FIFO has room
  always_comb begin
    o_src_ready = '0;
    if (w_busy && !i_fifo_full) o_src_ready[r_cur_src] = 1'b1;
  end

  assign o_fifo_wr_en  = w_wr;
  assign o_fifo_din    = w_busy ? w_data[r_cur_src] : '0;
  assign o_gnt         = r_gnt;
  assign o_busy        = w_busy;
  assign o_cur_src     = r_cur_src;
  assign o_burst_done  = r_done;
  assign o_burst_abort = r_abort;

endmodule

// File: tb/tb_sd_fifo_wr_arbiter.sv
// Directed testbench for sd_fifo_wr_arbiter (WIDTH=8, N_REQ=2, LEN_W=4, TMO_W=4).
module tb_sd_fifo_wr_arbiter;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned N_REQ = 2;
  localparam int unsigned LEN_W = 4;
  localparam int unsigned TMO_W = 4;

  logic                   wr_clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       i_req;
  logic [N_REQ*LEN_W-1:0] i_req_len;
  logic [N_REQ-1:0]       i_src_valid;
  logic [N_REQ*WIDTH-1:0] i_src_data;
  logic [N_REQ-1:0]       o_gnt;
  logic [N_REQ-1:0]       o_src_ready;
  logic                   o_fifo_wr_en;
  logic [WIDTH-1:0]       o_fifo_din;
  logic                   i_fifo_full;
  logic                   o_busy;
  logic [0:0]             o_cur_src;
  logic                   o_burst_done;
  logic                   o_burst_abort;

  sd_fifo_wr_arbiter #(
    .WIDTH(WIDTH), .N_REQ(N_REQ), .LEN_W(LEN_W), .TMO_W(TMO_W)
  ) dut (
    .wr_clk       (wr_clk),
    .rst          (rst),
    .i_req        (i_req),
    .i_req_len    (i_req_len),
    .i_src_valid  (i_src_valid),
    .i_src_data   (i_src_data),
    .o_gnt        (o_gnt),
    .o_src_ready  (o_src_ready),
    .o_fifo_wr_en (o_fifo_wr_en),
    .o_fifo_din   (o_fifo_din),
    .i_fifo_full  (i_fifo_full),
    .o_busy       (o_busy),
    .o_cur_src    (o_cur_src),
    .o_burst_done (o_burst_done),
    .o_burst_abort(o_burst_abort)
  );

  always #5 wr_clk = ~wr_clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] pat0[$];
  logic [7:0] pat1[$];
  int idx0 = 0;
  int idx1 = 0;

  logic [7:0] wr_q[$];
  int n_done  = 0;
  int n_abort = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Capture the FIFO write stream and pulse counts mid-cycle
  always @(negedge wr_clk) begin
    if (o_fifo_wr_en === 1'b1) begin
      wr_q.push_back(o_fifo_din);
      chk("wr_while_full", 32'(i_fifo_full), 32'd0);
    end
    if (o_burst_done === 1'b1)  n_done++;
    if (o_burst_abort === 1'b1) n_abort++;
  end

  task automatic drive_data();
    logic [7:0] d0;
    logic [7:0] d1;
    d0 = (idx0 < pat0.size()) ? pat0[idx0] : 8'h00;
    d1 = (idx1 < pat1.size()) ? pat1[idx1] : 8'h00;
    i_src_data = {d1, d0};
  endtask

  task automatic load_pat(input int which, input int base, input int n);
    if (which == 0) begin
      pat0.delete(); idx0 = 0;
      for (int k = 0; k < n; k++) pat0.push_back(8'(base + k));
    end else begin
      pat1.delete(); idx1 = 0;
      for (int k = 0; k < n; k++) pat1.push_back(8'(base + k));
    end
    drive_data();
  endtask

  task automatic settle();
    #2;
  endtask

  // Sample handshakes, step one clock, advance source pointers
  task automatic adv();
    logic [N_REQ-1:0] hs;
    hs = i_src_valid & o_src_ready;
    @(posedge wr_clk);
    #1;
    if (hs[0]) idx0++;
    if (hs[1]) idx1++;
    drive_data();
  endtask

  task automatic clr();
    wr_q.delete();
    n_done  = 0;
    n_abort = 0;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_gnt"},   32'(o_gnt),         32'd0);
    chk({pfx, "_ready"}, 32'(o_src_ready),   32'd0);
    chk({pfx, "_wr_en"}, 32'(o_fifo_wr_en),  32'd0);
    chk({pfx, "_din"},   32'(o_fifo_din),    32'd0);
    chk({pfx, "_busy"},  32'(o_busy),        32'd0);
    chk({pfx, "_cur"},   32'(o_cur_src),     32'd0);
    chk({pfx, "_done"},  32'(o_burst_done),  32'd0);
    chk({pfx, "_abort"}, 32'(o_burst_abort), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_req = '0; i_src_valid = '0; i_fifo_full = 1'b0;
    adv();
    rst = 1'b0;
    adv();
  endtask

  logic [1:0] rr_gnt [13] = '{0, 1, 1, 0, 2, 2, 0, 1, 1, 0, 2, 2, 0};
  logic [7:0] rr_din [13] = '{8'h00, 8'h11, 8'h12, 8'h00, 8'h21, 8'h22, 8'h00,
                              8'h13, 8'h14, 8'h00, 8'h23, 8'h24, 8'h00};
  logic       rr_cur [13] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1};
  logic       rr_done[13] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};

  initial begin
    rst = 1'b1;
    i_req = '0; i_req_len = '0; i_src_valid = '0; i_src_data = '0; i_fifo_full = 1'b0;
    repeat (2) @(posedge wr_clk);
    #1;
    settle();
    chk_all_zero("reset");
    rst = 1'b0;
    adv();

    // Single burst of 4 words from requester 0
    clr();
    pat0 = '{8'h4f, 8'h46, 8'h6e, 8'h2c}; idx0 = 0; drive_data();
    i_req = 2'b01; i_req_len = {4'd0, 4'd3}; i_src_valid = 2'b01;
    settle();
    chk("t1_idle_busy", 32'(o_busy), 32'd0);
    adv();
    i_req = 2'b00;
    for (int j = 0; j < 4; j++) begin
      settle();
      chk("t1_gnt",   32'(o_gnt),        32'd1);
      chk("t1_ready", 32'(o_src_ready),  32'd1);
      chk("t1_wr_en", 32'(o_fifo_wr_en), 32'd1);
      chk("t1_din",   32'(o_fifo_din),   32'(pat0[j]));
      chk("t1_done_early", 32'(o_burst_done), 32'd0);
      adv();
    end
    settle();
    chk("t1_done", 32'(o_burst_done), 32'd1);
    chk("t1_gnt_after", 32'(o_gnt), 32'd0);
    chk("t1_busy_after", 32'(o_busy), 32'd0);
    chk("t1_din_idle", 32'(o_fifo_din), 32'd0);
    adv();
    settle();
    chk("t1_done_pulse", 32'(o_burst_done), 32'd0);
    chk("t1_nwords", 32'(wr_q.size()), 32'd4);
    chk("t1_w0", 32'(wr_q[0]), 32'h4f);
    chk("t1_w1", 32'(wr_q[1]), 32'h46);
    chk("t1_w2", 32'(wr_q[2]), 32'h6e);
    chk("t1_w3", 32'(wr_q[3]), 32'h2c);
    chk("t1_ndone", 32'(n_done), 32'd1);
    i_src_valid = 2'b00;

    // Round robin, both requesting, 2-word bursts
    do_reset();
    clr();
    pat0 = '{8'h11, 8'h12, 8'h13, 8'h14}; idx0 = 0;
    pat1 = '{8'h21, 8'h22, 8'h23, 8'h24}; idx1 = 0;
    drive_data();
    i_req = 2'b11; i_req_len = {4'd1, 4'd1}; i_src_valid = 2'b11;
    for (int j = 0; j < 13; j++) begin
      if (j == 12) i_req = 2'b00;
      settle();
      chk("t2_gnt",   32'(o_gnt),         32'(rr_gnt[j]));
      chk("t2_wr_en", 32'(o_fifo_wr_en),  32'(rr_gnt[j] != 2'b00));
      chk("t2_din",   32'(o_fifo_din),    32'(rr_din[j]));
      chk("t2_cur",   32'(o_cur_src),     32'(rr_cur[j]));
      chk("t2_done",  32'(o_burst_done),  32'(rr_done[j]));
      adv();
    end
    settle();
    chk("t2_idle_end", 32'(o_busy), 32'd0);
    chk("t2_ndone", 32'(n_done), 32'd4);
    i_src_valid = 2'b00;

    // Backpressure: full for 5 cycles after word 2 of an 8-word burst
    clr();
    load_pat(0, 'h30, 8);
    i_req = 2'b01; i_req_len = {4'd0, 4'd7}; i_src_valid = 2'b01;
    for (int j = 0; j < 15; j++) begin
      automatic logic ex_wr;
      automatic logic ex_busy;
      if (j == 1) i_req = 2'b00;
      i_fifo_full = (j >= 3 && j <= 7);
      ex_busy = (j >= 1 && j <= 13);
      ex_wr   = (j >= 1 && j <= 2) || (j >= 8 && j <= 13);
      settle();
      chk("t3_busy",  32'(o_busy),        32'(ex_busy));
      chk("t3_wr_en", 32'(o_fifo_wr_en),  32'(ex_wr));
      chk("t3_ready", 32'(o_src_ready),   32'(ex_wr));
      chk("t3_abort", 32'(o_burst_abort), 32'd0);
      if (ex_wr) chk("t3_din", 32'(o_fifo_din), 32'('h30 + ((j <= 2) ? j - 1 : j - 6)));
      if (j == 14) chk("t3_done", 32'(o_burst_done), 32'd1);
      adv();
    end
    chk("t3_nwords", 32'(wr_q.size()), 32'd8);
    for (int k = 0; k < 8; k++) chk("t3_word", 32'(wr_q[k]), 32'('h30 + k));
    chk("t3_ndone", 32'(n_done), 32'd1);
    chk("t3_nabort", 32'(n_abort), 32'd0);
    i_src_valid = 2'b00;

    // Timeout: source 0 stalls 16 cycles after 2 of 6 words
    clr();
    load_pat(0, 'h40, 6);
    pat1 = '{8'h50}; idx1 = 0; drive_data();
    i_req = 2'b01; i_req_len = {4'd0, 4'd5}; i_src_valid = 2'b01;
    for (int j = 0; j < 22; j++) begin
      if (j == 1) i_req = 2'b00;
      if (j == 3) i_src_valid = 2'b00;
      if (j == 19) begin i_req = 2'b11; i_src_valid = 2'b11; end
      if (j == 20) i_req = 2'b00;
      settle();
      if (j >= 3 && j <= 18) begin
        chk("t4_busy_stall", 32'(o_busy), 32'd1);
        chk("t4_wr_stall", 32'(o_fifo_wr_en), 32'd0);
        chk("t4_abort_early", 32'(o_burst_abort), 32'd0);
      end
      if (j == 19) begin
        chk("t4_abort", 32'(o_burst_abort), 32'd1);
        chk("t4_done_none", 32'(o_burst_done), 32'd0);
        chk("t4_gnt_off", 32'(o_gnt), 32'd0);
        chk("t4_idle", 32'(o_busy), 32'd0);
      end
      if (j == 20) begin
        chk("t4_next_gnt", 32'(o_gnt), 32'd2);
        chk("t4_next_cur", 32'(o_cur_src), 32'd1);
        chk("t4_next_din", 32'(o_fifo_din), 32'h50);
        chk("t4_abort_pulse", 32'(o_burst_abort), 32'd0);
      end
      if (j == 21) chk("t4_next_done", 32'(o_burst_done), 32'd1);
      adv();
    end
    chk("t4_nabort", 32'(n_abort), 32'd1);
    chk("t4_ndone", 32'(n_done), 32'd1);
    chk("t4_nwords", 32'(wr_q.size()), 32'd3);
    chk("t4_w0", 32'(wr_q[0]), 32'h40);
    chk("t4_w1", 32'(wr_q[1]), 32'h41);
    chk("t4_w2", 32'(wr_q[2]), 32'h50);
    i_src_valid = 2'b00;

    // Reset mid-burst after 3 of 16 words, then a full 16-word burst on req[1]
    clr();
    load_pat(0, 'h60, 16);
    i_req = 2'b01; i_req_len = {4'd0, 4'd15}; i_src_valid = 2'b01;
    for (int j = 0; j < 4; j++) begin
      if (j == 1) i_req = 2'b00;
      settle();
      if (j >= 1) chk("t5_pre_wr", 32'(o_fifo_wr_en), 32'd1);
      adv();
    end
    chk("t5_pre_nwords", 32'(wr_q.size()), 32'd3);
    rst = 1'b1;
    #1;
    chk_all_zero("t5_rst");
    i_req = '0; i_src_valid = '0;
    adv();
    rst = 1'b0;
    adv();
    clr();
    load_pat(1, 'h70, 16);
    i_req = 2'b10; i_req_len = {4'd15, 4'd0}; i_src_valid = 2'b10;
    for (int j = 0; j < 18; j++) begin
      if (j == 1) i_req = 2'b00;
      settle();
      if (j >= 1 && j <= 16) begin
        chk("t5_gnt", 32'(o_gnt), 32'd2);
        chk("t5_wr_en", 32'(o_fifo_wr_en), 32'd1);
        chk("t5_din", 32'(o_fifo_din), 32'('h70 + j - 1));
      end
      if (j == 17) chk("t5_done", 32'(o_burst_done), 32'd1);
      adv();
    end
    chk("t5_nwords", 32'(wr_q.size()), 32'd16);
    chk("t5_ndone", 32'(n_done), 32'd1);
    i_src_valid = 2'b00;

    // Max length with fifo_full toggling every other cycle
    clr();
    load_pat(0, 'h80, 16);
    i_req = 2'b01; i_req_len = {4'd0, 4'd15}; i_src_valid = 2'b01;
    settle();
    adv();
    for (int j = 1; j < 35; j++) begin
      if (j == 1) i_req = 2'b00;
      i_fifo_full = (j % 2 == 0);
      settle();
      if (i_fifo_full) chk("t6_nowr_full", 32'(o_fifo_wr_en), 32'd0);
      if (j == 31) chk("t6_last_wr", 32'(o_fifo_wr_en), 32'd1);
      if (j == 32) begin
        chk("t6_done", 32'(o_burst_done), 32'd1);
        chk("t6_idle", 32'(o_busy), 32'd0);
      end
      adv();
    end
    i_fifo_full = 1'b0;
    chk("t6_nwords", 32'(wr_q.size()), 32'd16);
    for (int k = 0; k < 16; k++) chk("t6_word", 32'(wr_q[k]), 32'('h80 + k));
    chk("t6_ndone", 32'(n_done), 32'd1);
    chk("t6_nabort", 32'(n_abort), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
